// File: rtl/accel_spi_scheduler_if.sv
// rtl/accel_spi_scheduler_if.sv - byte-level handshake between the accel scheduler and the shared SPI engine
interface accel_spi_scheduler_if;
    logic       spi_start;
    logic [7:0] spi_tx_byte;
    logic       spi_hold;
    logic       spi_done;
    logic [7:0] spi_rx_byte;

    modport master (
        output spi_start,
        output spi_tx_byte,
        output spi_hold,
        input  spi_done,
        input  spi_rx_byte
    );

    modport slave (
        input  spi_start,
        input  spi_tx_byte,
        input  spi_hold,
        output spi_done,
        output spi_rx_byte
    );
endinterface

// File: rtl/accel_spi_scheduler.sv
// rtl/accel_spi_scheduler.sv - ADXL345 config + periodic 6-byte burst reader; watchdog optional via ACCEL_SPI_TIMEOUT_EN
module accel_spi_scheduler #(
    parameter int         SAMPLE_DIV  = 1000000,
    parameter logic [7:0] FORMAT_VAL  = 8'h0B,
    parameter logic [7:0] POWER_VAL   = 8'h08,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  cfg_req,
    accel_spi_scheduler_if.master spi,
    output logic [15:0]           x_data,
    output logic [15:0]           y_data,
    output logic [15:0]           z_data,
    output logic                  sample_valid,
    output logic                  cfg_done,
    output logic                  busy,
    output logic                  err
);

    localparam int         CNT_W     = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [7:0] ADDR_FMT  = 8'h31;
    localparam logic [7:0] ADDR_PWR  = 8'h2D;
    localparam logic [7:0] CMD_BURST = 8'hF2;
    localparam logic [2:0] LAST_IDX  = 3'd5;

    if (SAMPLE_DIV < 64 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("accel_spi_scheduler: SAMPLE_DIV must be >= 64 and TIMEOUT_CYC >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG_ADDR,
        S_CFG_DATA,
        S_RD_CMD,
        S_RD_BYTE,
        S_PUBLISH
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             cfg_pass;
    logic             cfg_pending;
    logic             waiting;
    logic [2:0]       rd_idx;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       shadow [6];

    logic             wrap;
    logic             xfer_state;
    logic             done_evt;
    logic             timeout;
    logic             cfg_finish;
    logic             start_c;
    logic [7:0]       tx_c;
    logic             hold_c;

    assign wrap       = enable && (cnt == DIV_LAST);
    assign xfer_state = (state == S_CFG_ADDR) || (state == S_CFG_DATA) ||
                        (state == S_RD_CMD)   || (state == S_RD_BYTE);
    assign done_evt   = waiting && spi.spi_done;
    assign cfg_finish = (state == S_CFG_DATA) && done_evt && cfg_pass;

`ifdef ACCEL_SPI_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd;

    assign timeout = waiting && !spi.spi_done && (wd == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd  <= '0;
            err <= 1'b0;
        end else begin
            wd <= (waiting && !spi.spi_done && !timeout) ? wd + WD_W'(1) : '0;
            if (timeout)
                err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_CFG_ADDR;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                // A request arriving on the wrap cycle takes priority; that slot is lost.
                if (cfg_pending || cfg_req)
                    state_next = S_CFG_ADDR;
                else if (wrap)
                    state_next = S_RD_CMD;
            end
            S_CFG_ADDR: if (done_evt) state_next = S_CFG_DATA;
            S_CFG_DATA: if (done_evt) state_next = cfg_pass ? S_IDLE : S_CFG_ADDR;
            S_RD_CMD:   if (done_evt) state_next = S_RD_BYTE;
            S_RD_BYTE:  if (done_evt && rd_idx == LAST_IDX) state_next = S_PUBLISH;
            S_PUBLISH:  state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
        if (timeout)
            state_next = S_IDLE;
    end

    always_comb begin
        start_c = xfer_state && !waiting;
        tx_c    = 8'h00;
        hold_c  = 1'b0;
        case (state)
            S_CFG_ADDR: begin
                tx_c   = cfg_pass ? ADDR_PWR : ADDR_FMT;
                hold_c = 1'b1;
            end
            S_CFG_DATA: begin
                tx_c   = cfg_pass ? POWER_VAL : FORMAT_VAL;
                hold_c = 1'b0;
            end
            S_RD_CMD: begin
                tx_c   = CMD_BURST;
                hold_c = 1'b1;
            end
            S_RD_BYTE: begin
                tx_c   = 8'h00;
                hold_c = (rd_idx != LAST_IDX);
            end
            default: begin
                tx_c   = 8'h00;
                hold_c = 1'b0;
            end
        endcase
    end

    // SPI handshake outputs and status are registered so every output is 0 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi.spi_start   <= 1'b0;
            spi.spi_tx_byte <= 8'h00;
            spi.spi_hold    <= 1'b0;
            waiting         <= 1'b0;
            cfg_pass        <= 1'b0;
            cfg_pending     <= 1'b1;
            cfg_done        <= 1'b0;
            rd_idx          <= 3'd0;
            cnt             <= '0;
            x_data          <= 16'h0000;
            y_data          <= 16'h0000;
            z_data          <= 16'h0000;
            sample_valid    <= 1'b0;
            busy            <= 1'b0;
            for (int i = 0; i < 6; i++)
                shadow[i] <= 8'h00;
        end else begin
            spi.spi_start <= start_c;
            if (start_c) begin
                spi.spi_tx_byte <= tx_c;
                spi.spi_hold    <= hold_c;
            end else if (timeout) begin
                spi.spi_hold    <= 1'b0;
            end

            if (start_c)
                waiting <= 1'b1;
            else if (done_evt || timeout)
                waiting <= 1'b0;

            if (state == S_IDLE && state_next == S_CFG_ADDR)
                cfg_pass <= 1'b0;
            else if (state == S_CFG_DATA && done_evt && !cfg_pass)
                cfg_pass <= 1'b1;

            if (cfg_req || timeout)
                cfg_pending <= 1'b1;
            else if (cfg_finish)
                cfg_pending <= 1'b0;

            if (cfg_req)
                cfg_done <= 1'b0;
            else if (cfg_finish)
                cfg_done <= 1'b1;

            if (state == S_RD_CMD && done_evt)
                rd_idx <= 3'd0;
            else if (state == S_RD_BYTE && done_evt) begin
                shadow[rd_idx] <= spi.spi_rx_byte;
                rd_idx         <= rd_idx + 3'd1;
            end

            if (!enable)
                cnt <= '0;
            else if (cnt == DIV_LAST)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);

            // Axis words change only here, all three together.
            if (state == S_PUBLISH) begin
                x_data <= {shadow[1], shadow[0]};
                y_data <= {shadow[3], shadow[2]};
                z_data <= {shadow[5], shadow[4]};
            end
            sample_valid <= (state == S_PUBLISH);

            busy <= (state_next != S_IDLE) && (state_next != S_PUBLISH);
        end
    end

endmodule

// File: tb/tb_accel_spi_scheduler.sv
// tb/tb_accel_spi_scheduler.sv - directed/randomized bench for accel_spi_scheduler with an SPI engine responder
module tb_accel_spi_scheduler;
    localparam int DIV = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        cfg_req;
    logic [15:0] x_data, y_data, z_data;
    logic        sample_valid, cfg_done, busy, err;

    accel_spi_scheduler_if spi ();

    accel_spi_scheduler #(.SAMPLE_DIV(DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .cfg_req      (cfg_req),
        .spi          (spi),
        .x_data       (x_data),
        .y_data       (y_data),
        .z_data       (z_data),
        .sample_valid (sample_valid),
        .cfg_done     (cfg_done),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] tx; logic hold; int cyc; } xfer_t;
    typedef struct { logic [15:0] x; logic [15:0] y; logic [15:0] z; int cyc; } samp_t;

    xfer_t      xq[$];
    samp_t      sq[$];
    samp_t      esq[$];
    logic [7:0] rd_q[$];
    int         cyc = 0;
    int         overlap = 0;
    int         checks = 0;
    int         errors = 0;
    bit         fast_engine = 1'b0;
    bit         pend = 1'b0;

    // Monitor: logs every started byte and every published sample, flags overlapping starts.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (spi.spi_start) begin
                if (pend) overlap++;
                pend = 1'b1;
                xq.push_back('{spi.spi_tx_byte, spi.spi_hold, cyc});
            end
            if (spi.spi_done) pend = 1'b0;
            if (sample_valid) sq.push_back('{x_data, y_data, z_data, cyc});
        end
    end

    // SPI engine model: answers each byte after a latency; read bytes come from rd_q.
    initial begin
        logic [7:0] tx;
        int         lat;
        bit         abort;
        spi.spi_done    = 1'b0;
        spi.spi_rx_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && spi.spi_start) begin
                tx    = spi.spi_tx_byte;
                lat   = fast_engine ? int'($urandom_range(2, 5)) : 16;
                abort = 1'b0;
                repeat (lat - 1) begin
                    @(negedge clk);
                    if (!rst_n) abort = 1'b1;
                end
                if (!abort) begin
                    if (tx == 8'h00 && rd_q.size() > 0) spi.spi_rx_byte = rd_q.pop_front();
                    else                                spi.spi_rx_byte = 8'($urandom);
                    spi.spi_done = 1'b1;
                    @(negedge clk);
                    spi.spi_done = 1'b0;
                end
            end
        end
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_xq(string tag, int n, int budget);
        int t = 0;
        while (xq.size() < n && t < budget) begin @(negedge clk); t++; end
        check({tag, "_xfer_wait"}, 32'(xq.size() >= n), 32'd1);
    endtask

    task automatic wait_sq(string tag, int n, int budget);
        int t = 0;
        while (sq.size() < n && t < budget) begin @(negedge clk); t++; end
        check({tag, "_sample_wait"}, 32'(sq.size() >= n), 32'd1);
    endtask

    task automatic wait_cfg(string tag, int budget);
        int t = 0;
        while (cfg_done !== 1'b1 && t < budget) begin @(negedge clk); t++; end
        check({tag, "_cfg_done"}, 32'(cfg_done), 32'd1);
    endtask

    task automatic expect_xfer(string tag, logic [7:0] tx, logic hold);
        xfer_t e;
        check({tag, "_present"}, 32'(xq.size() > 0), 32'd1);
        if (xq.size() > 0) begin
            e = xq.pop_front();
            check({tag, "_tx"}, 32'(e.tx), 32'(tx));
            check({tag, "_hold"}, 32'(e.hold), 32'(hold));
        end
    endtask

    task automatic expect_cfg(string tag);
        expect_xfer({tag, "_fmt_addr"}, 8'h31, 1'b1);
        expect_xfer({tag, "_fmt_val"},  8'h0B, 1'b0);
        expect_xfer({tag, "_pwr_addr"}, 8'h2D, 1'b1);
        expect_xfer({tag, "_pwr_val"},  8'h08, 1'b0);
    endtask

    task automatic expect_burst(string tag, output int c);
        c = (xq.size() > 0) ? xq[0].cyc : -1;
        expect_xfer({tag, "_cmd"}, 8'hF2, 1'b1);
        for (int i = 0; i < 6; i++)
            expect_xfer({tag, "_rd"}, 8'h00, 1'(i < 5));
    endtask

    // bytes[7:0] is DATAX0 ... bytes[47:40] is DATAZ1
    task automatic push_burst(logic [47:0] bytes);
        samp_t s;
        for (int i = 0; i < 6; i++) rd_q.push_back(bytes[8*i +: 8]);
        s.x = bytes[15:0];
        s.y = bytes[31:16];
        s.z = bytes[47:32];
        s.cyc = 0;
        esq.push_back(s);
    endtask

    task automatic push_rand();
        logic [63:0] r;
        r = {$urandom, $urandom};
        push_burst(r[47:0]);
    endtask

    task automatic expect_sample(string tag);
        samp_t s, m;
        check({tag, "_present"}, 32'(sq.size() > 0 && esq.size() > 0), 32'd1);
        if (sq.size() > 0 && esq.size() > 0) begin
            s = sq.pop_front();
            m = esq.pop_front();
            check({tag, "_x"}, 32'(s.x), 32'(m.x));
            check({tag, "_y"}, 32'(s.y), 32'(m.y));
            check({tag, "_z"}, 32'(s.z), 32'(m.z));
        end
    endtask

    initial begin
        int c, c1, c2, e;
        int f2 [4];

        rst_n = 1'b0; enable = 1'b0; cfg_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_spi_start", 32'(spi.spi_start), 32'd0);
        check("rst_spi_hold", 32'(spi.spi_hold), 32'd0);
        check("rst_spi_tx", 32'(spi.spi_tx_byte), 32'd0);
        check("rst_cfg_done", 32'(cfg_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_x", 32'(x_data), 32'd0);

        // Configuration after reset, slow engine
        rst_n = 1'b1;
        wait_cfg("boot", 400);
        expect_cfg("boot");
        check("boot_no_sample", 32'(sq.size()), 32'd0);
        repeat (2) @(negedge clk);
        check("boot_idle_busy", 32'(busy), 32'd0);
        check("boot_no_extra", 32'(xq.size()), 32'd0);

        // Periodic bursts: one known vector, three random
        fast_engine = 1'b1;
        push_burst(48'h01_00_FF_F0_00_10);
        for (int i = 0; i < 3; i++) push_rand();
        enable = 1'b1;
        wait_sq("per", 4, 5 * DIV);
        @(negedge clk);
        enable = 1'b0;
        check("per_pulse_width", 32'(sq.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            expect_burst("per", f2[i]);
            expect_sample("per");
        end
        for (int i = 1; i < 4; i++)
            check("per_spacing", 32'(f2[i] - f2[i-1]), 32'(DIV));
        check("per_err", 32'(err), 32'd0);
        repeat (4) @(negedge clk);
        check("per_quiet", 32'(xq.size()), 32'd0);

        // cfg_req during byte 3 of a burst, then cfg_req on a wrap
        push_rand(); push_rand();
        enable = 1'b1;
        wait_xq("midcfg", 4, 2 * DIV);
        cfg_req = 1'b1;
        @(negedge clk);
        cfg_req = 1'b0;
        check("midcfg_done_drop", 32'(cfg_done), 32'd0);
        wait_sq("midcfg", 2, 3 * DIV);
        expect_burst("midcfg_a", c1);
        expect_cfg("midcfg");
        expect_burst("midcfg_b", c);
        check("midcfg_resume", 32'(c - c1), 32'(DIV));
        expect_sample("midcfg_a");
        expect_sample("midcfg_b");
        check("midcfg_cfg_done", 32'(cfg_done), 32'd1);

        while (cyc < c + DIV - 2) @(negedge clk);
        cfg_req = 1'b1;
        @(negedge clk);
        cfg_req = 1'b0;
        push_rand();
        wait_sq("coinc", 1, 3 * DIV);
        @(negedge clk);
        enable = 1'b0;
        expect_cfg("coinc");
        expect_burst("coinc", c2);
        check("coinc_slot_skipped", 32'(c2 - c), 32'(2 * DIV));
        expect_sample("coinc");

        // enable dropped mid-burst
        repeat (4) @(negedge clk);
        xq.delete();
        push_rand();
        enable = 1'b1;
        wait_xq("endrop", 3, 2 * DIV);
        enable = 1'b0;
        wait_sq("endrop", 1, DIV);
        expect_sample("endrop");
        expect_burst("endrop", c);
        repeat (3 * DIV) @(negedge clk);
        check("endrop_no_start", 32'(xq.size()), 32'd0);
        check("endrop_no_sample", 32'(sq.size()), 32'd0);
        push_rand();
        enable = 1'b1;
        e = cyc + 1;
        wait_xq("reen", 1, 2 * DIV);
        if (xq.size() > 0) check("reen_first_slot", 32'(xq[0].cyc - e), 32'(DIV));
        wait_sq("reen", 1, DIV);
        expect_sample("reen");
        expect_burst("reen", c);

        // asynchronous reset in the middle of a read
        push_rand();
        wait_xq("arst", 4, 2 * DIV);
        #3 rst_n = 1'b0;
        #1;
        check("arst_hold", 32'(spi.spi_hold), 32'd0);
        check("arst_start", 32'(spi.spi_start), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cfg_done", 32'(cfg_done), 32'd0);
        check("arst_x", 32'(x_data), 32'd0);
        check("arst_z", 32'(z_data), 32'd0);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        xq.delete(); sq.delete(); esq.delete(); rd_q.delete();
        rst_n = 1'b1;
        wait_cfg("arst", 200);
        expect_cfg("arst");
        check("arst_no_sample", 32'(sq.size()), 32'd0);

        check("one_outstanding", 32'(overlap), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
